// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - length codes, frame sizing and FSM states for the request scheduler
package sti_pkg;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  // ST_ prefix keeps the GAP state distinct from the GAP parameter of the top
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_SHIFT,
    ST_GAP
  } state_t;

  // 8 * (len + 1): 8/16/24/32
  function automatic logic [5:0] frame_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter: first set request at or after ptr, wrapping
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/sti_req_scheduler.sv
// rtl/sti_req_scheduler.sv - round-robin sharing of one serial transmitter between requesters
module sti_req_scheduler
  import sti_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int START_TO = 8,
  parameter int GAP      = 1,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_len,
  input  logic [NUM_REQ-1:0]   req_low,
  input  logic [NUM_REQ-1:0]   req_msb,
  input  logic [NUM_REQ-1:0]   req_fill,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 load,
  output logic [15:0]          pi_data,
  output logic [1:0]           pi_length,
  output logic                 pi_low,
  output logic                 pi_msb,
  output logic                 pi_fill,
  output logic                 pi_end,
  input  logic                 so_valid,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic                 err_timeout,
  output logic                 err_len
);

  logic [15:0] data_a [NUM_REQ];
  logic [1:0]  len_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_a[g] = req_data[16*g +: 16];
    assign len_a[g]  = req_len[2*g +: 2];
  end

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [5:0]    exp_bits, exp_bits_n;
  logic          last_q, last_n;
  logic [IW-1:0] ptr, ptr_n;

  logic [NUM_REQ-1:0] req_ready_n;
  logic               load_n, pi_end_n, err_timeout_n, err_len_n;
  logic [15:0]        pi_data_n;
  logic [1:0]         pi_length_n;
  logic               pi_low_n, pi_msb_n, pi_fill_n;
  logic [IW-1:0]      grant_id_n;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    exp_bits_n    = exp_bits;
    last_n        = last_q;
    ptr_n         = ptr;
    req_ready_n   = '0;
    load_n        = 1'b0;
    pi_end_n      = 1'b0;
    err_timeout_n = err_timeout;
    err_len_n     = err_len;
    pi_data_n     = pi_data;
    pi_length_n   = pi_length;
    pi_low_n      = pi_low;
    pi_msb_n      = pi_msb;
    pi_fill_n     = pi_fill;
    grant_id_n    = grant_id;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_n = arb_grant;
          load_n      = 1'b1;
          grant_id_n  = arb_idx;
          pi_data_n   = data_a[arb_idx];
          pi_length_n = len_a[arb_idx];
          pi_low_n    = req_low[arb_idx];
          pi_msb_n    = req_msb[arb_idx];
          pi_fill_n   = req_fill[arb_idx];
          exp_bits_n  = frame_bits(len_a[arb_idx]);
          last_n      = req_last[arb_idx];
          ptr_n       = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_n       = '0;
          state_n     = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (so_valid) begin
          cnt_n   = 8'd1;
          state_n = ST_SHIFT;
        end else if (cnt == 8'(START_TO - 1)) begin
          err_timeout_n = 1'b1;
          cnt_n         = '0;
          state_n       = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (so_valid) begin
          if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
        end else begin
          if (cnt != {2'b00, exp_bits}) err_len_n = 1'b1;
          // registered, so it lands in the first cycle after the frame
          pi_end_n = last_q;
          cnt_n    = '0;
          state_n  = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == 8'(GAP - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      exp_bits    <= '0;
      last_q      <= 1'b0;
      ptr         <= '0;
      req_ready   <= '0;
      load        <= 1'b0;
      pi_end      <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      pi_data     <= '0;
      pi_length   <= '0;
      pi_low      <= 1'b0;
      pi_msb      <= 1'b0;
      pi_fill     <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      exp_bits    <= exp_bits_n;
      last_q      <= last_n;
      ptr         <= ptr_n;
      req_ready   <= req_ready_n;
      load        <= load_n;
      pi_end      <= pi_end_n;
      err_timeout <= err_timeout_n;
      err_len     <= err_len_n;
      pi_data     <= pi_data_n;
      pi_length   <= pi_length_n;
      pi_low      <= pi_low_n;
      pi_msb      <= pi_msb_n;
      pi_fill     <= pi_fill_n;
      grant_id    <= grant_id_n;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sti_req_scheduler.sv
// tb/tb_sti_req_scheduler.sv - scoreboard bench with a behavioural transmitter model
module tb_sti_req_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int START_TO = 8;
  localparam int GAP      = 1;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [7:0]  req_len;
  logic [3:0]  req_low, req_msb, req_fill, req_last;
  logic [3:0]  req_ready;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_low, pi_msb, pi_fill, pi_end;
  logic        so_valid;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout, err_len;

  sti_req_scheduler #(.NUM_REQ(NUM_REQ), .START_TO(START_TO), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_len(req_len), .req_low(req_low), .req_msb(req_msb), .req_fill(req_fill),
    .req_last(req_last), .req_ready(req_ready), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_low(pi_low), .pi_msb(pi_msb), .pi_fill(pi_fill),
    .pi_end(pi_end), .so_valid(so_valid), .busy(busy), .grant_id(grant_id),
    .err_timeout(err_timeout), .err_len(err_len)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [1:0]  len;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, load_cnt = 0, load_cyc = 0, pi_end_cnt = 0, pi_end_cyc = 0, so_fall_cyc = 0;
  bit tx_en = 1;
  int tx_ovr = -1;
  int tx_delay = 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // scoreboard: every load must match the oldest expected grant
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pi_end) begin
        pi_end_cnt = pi_end_cnt + 1;
        pi_end_cyc = cyc;
      end
      if (load) begin
        load_cnt = load_cnt + 1;
        load_cyc = cyc;
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL sb_unexpected_load grant_id=%0d expected no load", grant_id);
        end else begin
          e = sb.pop_front();
          if (grant_id !== 2'(e.id)) begin
            bad = bad + 1;
            $display("FAIL sb_grant_id got=%0d exp=%0d", grant_id, e.id);
          end
          total = total + 1;
          if (req_ready !== 4'(1 << e.id)) begin
            bad = bad + 1;
            $display("FAIL sb_req_ready got=%b exp=%b", req_ready, 4'(1 << e.id));
          end
          total = total + 1;
          if (pi_data !== e.data || pi_length !== e.len) begin
            bad = bad + 1;
            $display("FAIL sb_pi_word got=%h/%0d exp=%h/%0d", pi_data, pi_length, e.data, e.len);
          end
        end
      end
    end
  end

  // transmitter: after load, waits tx_delay cycles then raises so_valid for frame-bit cycles
  initial begin
    int nb;
    so_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (load && tx_en && !reset) begin
        nb = (tx_ovr >= 0) ? tx_ovr : 8 * (int'(pi_length) + 1);
        for (int k = 0; k < tx_delay && !reset; k++) @(negedge clk);
        if (!reset) begin
          so_valid = 1'b1;
          for (int k = 0; k < nb && !reset; k++) @(negedge clk);
          so_valid = 1'b0;
          so_fall_cyc = cyc;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] d, input logic [1:0] l,
                         input logic lo, input logic ms, input logic fi, input logic la);
    req_data[16*i +: 16] = d;
    req_len[2*i +: 2]    = l;
    req_low[i]  = lo;
    req_msb[i]  = ms;
    req_fill[i] = fi;
    req_last[i] = la;
  endtask

  task automatic push(input int id, input logic [15:0] d, input logic [1:0] l);
    exp_t e;
    e.id = id; e.data = d; e.len = l;
    sb.push_back(e);
  endtask

  task automatic wait_loads(input int target, input int budget, input bit drop);
    for (int k = 0; k < budget; k++) begin
      if (load_cnt >= target) break;
      @(negedge clk);
      if (drop) req_valid = req_valid & ~req_ready;
    end
    total = total + 1;
    if (load_cnt < target) begin
      bad = bad + 1;
      $display("FAIL wait_load loads=%0d need=%0d", load_cnt, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && !load) break;
    end
    @(negedge clk);
    total = total + 1;
    if (k == budget) begin
      bad = bad + 1;
      $display("FAIL wait_idle busy=%0b after %0d cycles need 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    total = total + 1;
    if ({load, req_ready, pi_data, pi_length, pi_low, pi_msb, pi_fill, pi_end,
         busy, grant_id, err_timeout, err_len} !== '0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs load=%0b ready=%b data=%h busy=%0b gid=%0d err=%0b%0b need all 0",
               load, req_ready, pi_data, busy, grant_id, err_timeout, err_len);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int pe0 = pi_end_cnt;
    int base = load_cnt;
    set_req(0, 16'hA5C3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    push(0, 16'hA5C3, 2'd3);
    req_valid = 4'b0001;
    wait_loads(base + 1, 20, 1);
    total = total + 1;
    if ({pi_low, pi_msb, pi_fill} !== 3'b011) begin
      bad = bad + 1;
      $display("FAIL single_format got=%b exp=011", {pi_low, pi_msb, pi_fill});
    end
    wait_idle(80);
    total = total + 1;
    if (pi_end_cnt != pe0 + 1 || pi_end_cyc != so_fall_cyc + 1) begin
      bad = bad + 1;
      $display("FAIL single_pi_end count=%0d exp=%0d at=%0d exp=%0d",
               pi_end_cnt - pe0, 1, pi_end_cyc, so_fall_cyc + 1);
    end
    total = total + 1;
    if ({err_timeout, err_len} !== 2'b00) begin
      bad = bad + 1;
      $display("FAIL single_errors got=%b exp=00", {err_timeout, err_len});
    end
  endtask

  task automatic test_round_robin();
    int base;
    int pe0;
    test_reset();
    base = load_cnt;
    pe0  = pi_end_cnt;
    for (int i = 0; i < 4; i++) set_req(i, 16'hB000 | 16'(i), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(0, 16'hB000, 2'd0); push(1, 16'hB001, 2'd0); push(2, 16'hB002, 2'd0);
    push(3, 16'hB003, 2'd0); push(0, 16'hB000, 2'd0);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_loads(base + n + 1, 60, 0);
      if (n > 0) begin
        total = total + 1;
        if (load_cyc - so_fall_cyc < GAP + 1) begin
          bad = bad + 1;
          $display("FAIL rr_gap frame=%0d gap=%0d need>=%0d", n, load_cyc - so_fall_cyc, GAP + 1);
        end
      end
    end
    req_valid = '0;
    wait_idle(60);
    repeat (4) @(negedge clk);
    total = total + 1;
    if (load_cnt != base + 5 || sb.size() != 0 || pi_end_cnt != pe0) begin
      bad = bad + 1;
      $display("FAIL rr_totals loads=%0d exp=5 pending=%0d pi_end=%0d exp=0",
               load_cnt - base, sb.size(), pi_end_cnt - pe0);
    end
  endtask

  task automatic test_wrap();
    int base = load_cnt;
    push(3, 16'hB003, 2'd0);
    req_valid = 4'b1000;
    wait_loads(base + 1, 20, 1);
    wait_idle(60);
    push(0, 16'hB000, 2'd0);
    push(2, 16'hB002, 2'd0);
    req_valid = 4'b0101;
    wait_loads(base + 3, 80, 1);
    wait_idle(60);
    total = total + 1;
    if (sb.size() != 0 || req_valid !== 4'b0000) begin
      bad = bad + 1;
      $display("FAIL wrap_pending pending=%0d valid=%b exp 0/0000", sb.size(), req_valid);
    end
  endtask

  task automatic test_timeout();
    int base = load_cnt;
    int pe0 = pi_end_cnt;
    int lc;
    int k;
    tx_en = 0;
    set_req(1, 16'h1234, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1, 16'h1234, 2'd1);
    req_valid = 4'b0010;
    wait_loads(base + 1, 20, 1);
    lc = load_cyc;
    for (k = 0; k < 30; k++) begin
      if (err_timeout) break;
      @(negedge clk);
    end
    total = total + 1;
    if (err_timeout !== 1'b1 || cyc - lc != START_TO) begin
      bad = bad + 1;
      $display("FAIL timeout_at flag=%0b after=%0d exp=1 after %0d", err_timeout, cyc - lc, START_TO);
    end
    wait_idle(20);
    total = total + 1;
    if (pi_end_cnt != pe0 || err_len !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL timeout_side pi_end=%0d err_len=%0b exp 0/0", pi_end_cnt - pe0, err_len);
    end
    tx_en = 1;
    set_req(1, 16'h4321, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, 16'h4321, 2'd1);
    req_valid = 4'b0010;
    wait_loads(base + 2, 20, 1);
    wait_idle(60);
    total = total + 1;
    if ({err_timeout, err_len} !== 2'b10) begin
      bad = bad + 1;
      $display("FAIL timeout_sticky got=%b exp=10", {err_timeout, err_len});
    end
  endtask

  task automatic test_len_error();
    int base = load_cnt;
    int k;
    tx_ovr = 15;
    set_req(2, 16'h5A5A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(2, 16'h5A5A, 2'd1);
    req_valid = 4'b0100;
    wait_loads(base + 1, 20, 1);
    for (k = 0; k < 60; k++) begin
      if (err_len) break;
      @(negedge clk);
    end
    total = total + 1;
    if (err_len !== 1'b1 || cyc != so_fall_cyc + 1) begin
      bad = bad + 1;
      $display("FAIL len_err flag=%0b at=%0d exp=1 at %0d", err_len, cyc, so_fall_cyc + 1);
    end
    wait_idle(20);
    tx_ovr = -1;
    push(2, 16'h5A5A, 2'd1);
    req_valid = 4'b0100;
    wait_loads(base + 2, 20, 1);
    wait_idle(60);
    total = total + 1;
    if (err_len !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL len_sticky got=%0b exp=1", err_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = load_cnt;
    int pe0;
    set_req(1, 16'hC0DE, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    push(1, 16'hC0DE, 2'd2);
    req_valid = 4'b0010;
    wait_loads(base + 1, 20, 1);
    repeat (10) @(negedge clk);
    total = total + 1;
    if (busy !== 1'b1 || so_valid !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL mid_shift busy=%0b so_valid=%0b exp 1/1", busy, so_valid);
    end
    pe0 = pi_end_cnt;
    reset = 1'b1;
    @(negedge clk);
    total = total + 1;
    if ({load, req_ready, pi_data, pi_length, pi_low, pi_msb, pi_fill, pi_end,
         busy, grant_id, err_timeout, err_len} !== '0) begin
      bad = bad + 1;
      $display("FAIL mid_reset_outputs busy=%0b data=%h gid=%0d err=%0b%0b need all 0",
               busy, pi_data, grant_id, err_timeout, err_len);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_req(0, 16'h0F0F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_req(2, 16'h2222, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(0, 16'h0F0F, 2'd0);
    push(2, 16'h2222, 2'd0);
    req_valid = 4'b0101;
    wait_loads(base + 3, 80, 1);
    wait_idle(60);
    total = total + 1;
    if (sb.size() != 0 || pi_end_cnt != pe0 + 1 || {err_timeout, err_len} !== 2'b00) begin
      bad = bad + 1;
      $display("FAIL post_reset pending=%0d pi_end=%0d exp=1 err=%b exp=00",
               sb.size(), pi_end_cnt - pe0, {err_timeout, err_len});
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_len   = '0;
    req_low   = '0;
    req_msb   = '0;
    req_fill  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_len_error();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sti_req_scheduler.md
Name: sti_req_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial transmitter (16-bit pi_data, length/low/msb/fill controls, serial so_data/so_valid) between NUM_REQ requesters.
- Accepts one word plus format from the granted requester and issues a one-cycle load to the transmitter.
- Tracks the serial frame through so_valid and only then arbitrates again. Non-preemptive; one frame in flight at a time.
- Generates pi_end after the last frame of a session and flags framing errors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TO, 8, max cycles from load to so_valid rise before timeout
GAP, 1, idle cycles inserted between consecutive frames (0..3)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a word pending; held until req_ready[i]
req_data  in  16*NUM_REQ  word of requester i, slice [16i+15:16i]
req_len  in  2*NUM_REQ  length code: 0=8b, 1=16b, 2=24b, 3=32b
req_low  in  NUM_REQ  select low byte (8b only)
req_msb  in  NUM_REQ  MSB-first
req_fill  in  NUM_REQ  fill position (24b/32b only)
req_last  in  NUM_REQ  word is the last of requester's session
req_ready  out  NUM_REQ  one-hot acceptance pulse
load  out  1  one-cycle load strobe to transmitter
pi_data  out  16  held word
pi_length  out  2  held length code
pi_low, pi_msb, pi_fill  out  1 each  held format bits
pi_end  out  1  one-cycle end-of-session pulse
so_valid  in  1  transmitter serial-valid
busy  out  1  frame in flight (state != IDLE)
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
err_timeout  out  1  sticky: so_valid not seen within START_TO
err_len  out  1  sticky: so_valid high-count != expected bits

Behaviour:
- Reset: all outputs 0; rr pointer=0 (req 0 highest priority); state IDLE; bit counter 0; sticky errors cleared. Only reset clears errors.
- Frame bits: 8*(len+1), i.e. 8/16/24/32.
- IDLE:
  - If any req_valid: pick first set bit at or after rr pointer, wrapping.
  - Register that requester's data/format into pi_* and the frame bit count.
  - Assert req_ready[g] and load in the same cycle (registered outputs, so both high the cycle after grant decision). Go to WAIT_START.
  - Pointer becomes g+1 mod NUM_REQ.
- pi_* hold from load until the next grant; load is exactly one cycle.
- WAIT_START:
  - Count cycles. On so_valid=1, go to SHIFT with bit count=1.
  - If count reaches START_TO without so_valid: set err_timeout, go to GAP. No pi_end.
- SHIFT:
  - Increment count each cycle so_valid=1.
  - On so_valid=0: set err_len if count != expected. Go to GAP.
  - If the frame was req_last, pulse pi_end in the first GAP cycle.
- GAP: wait GAP cycles, then IDLE. GAP=0: pi_end, if any, is issued in the IDLE cycle. A new grant is allowed in that same cycle.
- Requesters may assert req_valid at any time; arbitration only samples in IDLE.
- A req_valid dropped before ready is legal and ignored; a request seen at arbitration time is granted.
- Simultaneous requests: strict round-robin. A single requester with continuous valid is granted back-to-back, separated by GAP.
- so_valid high while in IDLE/GAP: ignored, no error.
- Reset mid-frame: everything returns to reset values immediately. The transmitter is reset by the same signal.

Decomposition:
- Package sti_pkg:
  - length code constants LEN8/16/24/32.
  - function frame_bits(len), returning 6 bits.
  - state enum IDLE/WAIT_START/SHIFT/GAP.
- One sub-module rr_arb: NUM_REQ-wide round-robin arbiter.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.

Test Plan:
1. Single req 0: len=3, data=16'hA5C3, msb=1, fill=1, last=1 → one load; req_ready=4'b0001; so_valid high 32 cycles; pi_end pulse once; no errors.
2. req_valid=4'b1111 held, len=0 → grants in order 0,1,2,3,0. grant_id sequence 0,1,2,3,0. One load per frame, ≥GAP idle cycles between so_valid falls and next load.
3. Pointer wrap: after a grant to 3, req_valid=4'b0101 → grant 0, then 2.
4. Model withholds so_valid → err_timeout=1 exactly START_TO cycles after load. Returns to IDLE; next request still served.
5. Model emits 15 valid bits for len=1 → err_len=1 at so_valid fall. Sticky until reset.
6. Assert reset during SHIFT of a 24-bit frame → all outputs 0 next sample, pointer=0. The post-reset request from req 2 is granted normally.
